// File: rtl/mgr_noc_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mgr_noc_tx_arbiter
//
// Packet-atomic round-robin arbiter that shares the manager's local->NoC port
// among NUM_REQ local sources. A grant is taken on an accepted SOM (or SOM_EOM)
// beat and held until the matching EOM beat is accepted, so packets from
// different sources never interleave. Beats pass through a single registered
// output stage that sustains one beat per cycle under continuous NoC ready.
//
// Control encoding (req__arb__cntl / locl__noc__dp_cntl):
//   2'b01 SOM, 2'b00 MOM, 2'b10 EOM, 2'b11 SOM_EOM
//
// Ports
//   clk                  in   clock, all logic on posedge
//   reset_poweron        in   synchronous active-high reset
//   req__arb__valid      in   [NUM_REQ]         per-requester beat valid
//   req__arb__cntl       in   [2*NUM_REQ]       per-requester SOM/MOM/EOM/SOM_EOM
//   req__arb__type       in   [TYPE_W*NUM_REQ]  packet type
//   req__arb__ptype      in   [TYPE_W*NUM_REQ]  payload type
//   req__arb__desttype   in   [TYPE_W*NUM_REQ]  destination type
//   req__arb__pvalid     in   [NUM_REQ]         payload valid
//   req__arb__data       in   [DATA_W*NUM_REQ]  beat data
//   arb__req__ready      out  [NUM_REQ]         beat taken when valid[i] & ready[i]
//   locl__noc__dp_*      out  registered output beat towards the NoC
//   noc__locl__dp_ready  in   NoC takes the output beat when valid & ready
//   arb__grant_id        out  [clog2(NUM_REQ)]  current / last granted requester
//
// Build option
//   MGR_NOC_TX_ARB_REQ0_PRIORITY_EN : requester 0 wins every idle arbitration it
//   takes part in and its grants do not move the round-robin pointer. Grants are
//   still never preempted mid-packet.
// -----------------------------------------------------------------------------
module mgr_noc_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int TYPE_W  = 2
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic [NUM_REQ-1:0]          req__arb__valid,
    input  logic [2*NUM_REQ-1:0]        req__arb__cntl,
    input  logic [TYPE_W*NUM_REQ-1:0]   req__arb__type,
    input  logic [TYPE_W*NUM_REQ-1:0]   req__arb__ptype,
    input  logic [TYPE_W*NUM_REQ-1:0]   req__arb__desttype,
    input  logic [NUM_REQ-1:0]          req__arb__pvalid,
    input  logic [DATA_W*NUM_REQ-1:0]   req__arb__data,
    output logic [NUM_REQ-1:0]          arb__req__ready,
    output logic                        locl__noc__dp_valid,
    output logic [1:0]                  locl__noc__dp_cntl,
    output logic [TYPE_W-1:0]           locl__noc__dp_type,
    output logic [TYPE_W-1:0]           locl__noc__dp_ptype,
    output logic [TYPE_W-1:0]           locl__noc__dp_desttype,
    output logic                        locl__noc__dp_pvalid,
    output logic [DATA_W-1:0]           locl__noc__dp_data,
    input  logic                        noc__locl__dp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  arb__grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {ST_IDLE, ST_PKT} state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr, rr_next;
    logic [ID_W-1:0]   grant_next;
    logic [ID_W-1:0]   winner, cur_id, scan_id;
    logic              found, out_free, accept, beat_eom;
    logic [NUM_REQ-1:0] som_valid, ready_int;
    int                scan_sum;

    logic [1:0]        cntl_arr     [NUM_REQ];
    logic [TYPE_W-1:0] type_arr     [NUM_REQ];
    logic [TYPE_W-1:0] ptype_arr    [NUM_REQ];
    logic [TYPE_W-1:0] desttype_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr     [NUM_REQ];

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g);
        return (g == LAST_ID) ? '0 : g + 1'b1;
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign cntl_arr[gi]     = req__arb__cntl[gi*2 +: 2];
        assign type_arr[gi]     = req__arb__type[gi*TYPE_W +: TYPE_W];
        assign ptype_arr[gi]    = req__arb__ptype[gi*TYPE_W +: TYPE_W];
        assign desttype_arr[gi] = req__arb__desttype[gi*TYPE_W +: TYPE_W];
        assign data_arr[gi]     = req__arb__data[gi*DATA_W +: DATA_W];
        assign som_valid[gi]    = req__arb__valid[gi] &
                                  ((cntl_arr[gi] == CNTL_SOM) || (cntl_arr[gi] == CNTL_SOM_EOM));
    end

    // Idle arbitration: first requester presenting a start-of-message beat,
    // scanning upward from the round-robin pointer with wrap-around.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_sum = 0;
        scan_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
            scan_id = ID_W'(scan_sum);
            if (!found && som_valid[scan_id]) begin
                found  = 1'b1;
                winner = scan_id;
            end
        end
`ifdef MGR_NOC_TX_ARB_REQ0_PRIORITY_EN
        if (som_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    // Ready goes only to the requester being served, and only when the output
    // register will be free at the next edge. Held low during reset so no beat
    // is ever handshaken while the stage is being cleared.
    always_comb begin
        cur_id    = (state == ST_IDLE) ? winner : arb__grant_id;
        out_free  = ~locl__noc__dp_valid | noc__locl__dp_ready;
        ready_int = '0;
        if (!reset_poweron && out_free) begin
            if (state == ST_PKT)
                ready_int[arb__grant_id] = 1'b1;
            else if (found)
                ready_int[winner] = 1'b1;
        end
        accept   = |(ready_int & req__arb__valid);
        beat_eom = (cntl_arr[cur_id] == CNTL_EOM) || (cntl_arr[cur_id] == CNTL_SOM_EOM);
    end

    assign arb__req__ready = ready_int;

    // Next-state: a grant opens on an accepted idle beat and closes on an
    // accepted EOM; a SOM_EOM beat does both in the same cycle.
    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        grant_next = arb__grant_id;
        if (accept) begin
            grant_next = cur_id;
            if (beat_eom) begin
                state_next = ST_IDLE;
`ifdef MGR_NOC_TX_ARB_REQ0_PRIORITY_EN
                rr_next = (cur_id == '0) ? rr_ptr : next_id(cur_id);
`else
                rr_next = next_id(cur_id);
`endif
            end else begin
                state_next = ST_PKT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            arb__grant_id <= '0;
        end else begin
            state         <= state_next;
            rr_ptr        <= rr_next;
            arb__grant_id <= grant_next;
        end
    end

    // Output stage: loads on accept, otherwise holds until the NoC takes it.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            locl__noc__dp_valid    <= 1'b0;
            locl__noc__dp_cntl     <= CNTL_MOM;
            locl__noc__dp_type     <= '0;
            locl__noc__dp_ptype    <= '0;
            locl__noc__dp_desttype <= '0;
            locl__noc__dp_pvalid   <= 1'b0;
            locl__noc__dp_data     <= '0;
        end else if (accept) begin
            locl__noc__dp_valid    <= 1'b1;
            locl__noc__dp_cntl     <= cntl_arr[cur_id];
            locl__noc__dp_type     <= type_arr[cur_id];
            locl__noc__dp_ptype    <= ptype_arr[cur_id];
            locl__noc__dp_desttype <= desttype_arr[cur_id];
            locl__noc__dp_pvalid   <= req__arb__pvalid[cur_id];
            locl__noc__dp_data     <= data_arr[cur_id];
        end else if (noc__locl__dp_ready) begin
            locl__noc__dp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mgr_noc_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mgr_noc_tx_arbiter
//
// Directed bench for mgr_noc_tx_arbiter (NUM_REQ=4, DATA_W=64, TYPE_W=2).
// Inputs change 1 time unit after each rising edge; registered outputs are
// read at that same point, combinational ready 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mgr_noc_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int TYPE_W  = 2;

    localparam logic [1:0] MOM     = 2'b00;
    localparam logic [1:0] SOM     = 2'b01;
    localparam logic [1:0] EOM     = 2'b10;
    localparam logic [1:0] SOM_EOM = 2'b11;

    logic                       clk = 1'b0;
    logic                       reset_poweron;
    logic [NUM_REQ-1:0]         req_valid;
    logic [2*NUM_REQ-1:0]       req_cntl;
    logic [TYPE_W*NUM_REQ-1:0]  req_type, req_ptype, req_desttype;
    logic [NUM_REQ-1:0]         req_pvalid;
    logic [DATA_W*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       dp_valid;
    logic [1:0]                 dp_cntl;
    logic [TYPE_W-1:0]          dp_type, dp_ptype, dp_desttype;
    logic                       dp_pvalid;
    logic [DATA_W-1:0]          dp_data;
    logic                       dp_ready;
    logic [1:0]                 grant_id;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    mgr_noc_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TYPE_W(TYPE_W)) dut (
        .clk                    (clk),
        .reset_poweron          (reset_poweron),
        .req__arb__valid        (req_valid),
        .req__arb__cntl         (req_cntl),
        .req__arb__type         (req_type),
        .req__arb__ptype        (req_ptype),
        .req__arb__desttype     (req_desttype),
        .req__arb__pvalid       (req_pvalid),
        .req__arb__data         (req_data),
        .arb__req__ready        (req_ready),
        .locl__noc__dp_valid    (dp_valid),
        .locl__noc__dp_cntl     (dp_cntl),
        .locl__noc__dp_type     (dp_type),
        .locl__noc__dp_ptype    (dp_ptype),
        .locl__noc__dp_desttype (dp_desttype),
        .locl__noc__dp_pvalid   (dp_pvalid),
        .locl__noc__dp_data     (dp_data),
        .noc__locl__dp_ready    (dp_ready),
        .arb__grant_id          (grant_id)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one requester's beat; type fields derive from the id so the
    // output mux selection can be checked.
    task automatic applyStimulus(input int id, input logic v, input logic [1:0] c, input logic [63:0] d);
        req_valid[id]               = v;
        req_cntl[id*2 +: 2]         = c;
        req_data[id*DATA_W +: DATA_W] = d;
        req_type[id*TYPE_W +: TYPE_W]     = 2'(id);
        req_ptype[id*TYPE_W +: TYPE_W]    = 2'(3 - id);
        req_desttype[id*TYPE_W +: TYPE_W] = 2'(id + 1);
        req_pvalid[id]              = 1'b1;
    endtask

    task automatic clearAll();
        req_valid    = '0;
        req_cntl     = '0;
        req_type     = '0;
        req_ptype    = '0;
        req_desttype = '0;
        req_pvalid   = '0;
        req_data     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_poweron = 1'b1;
        repeat (3) tick();
        reset_poweron = 1'b0;
    endtask

    initial begin
        clearAll();
        dp_ready      = 1'b1;
        reset_poweron = 1'b0;
        #1;
        doReset();

        // Reset values
        checkOutput("rst_dp_valid", 64'(dp_valid), 64'd0);
        checkOutput("rst_dp_data", dp_data, 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_grant", 64'(grant_id), 64'd0);

        // Requester 1: four-beat packet, continuous NoC ready
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 1'b1, (b == 0) ? SOM : ((b == 3) ? EOM : MOM), 64'hA0 + 64'(b));
            #1;
            checkOutput($sformatf("p1_ready%0d", b), 64'(req_ready), 64'b0010);
            tick();
            checkOutput($sformatf("p1_valid%0d", b), 64'(dp_valid), 64'd1);
            checkOutput($sformatf("p1_data%0d", b), dp_data, 64'hA0 + 64'(b));
            checkOutput($sformatf("p1_cntl%0d", b), 64'(dp_cntl),
                        64'((b == 0) ? SOM : ((b == 3) ? EOM : MOM)));
        end
        checkOutput("p1_type", 64'(dp_type), 64'd1);
        checkOutput("p1_ptype", 64'(dp_ptype), 64'd2);
        checkOutput("p1_dtype", 64'(dp_desttype), 64'd2);
        checkOutput("p1_grant", 64'(grant_id), 64'd1);
        clearAll();
        tick();
        checkOutput("p1_drain", 64'(dp_valid), 64'd0);

        // Non-SOM beat while idle is not accepted
        applyStimulus(3, 1'b1, MOM, 64'h33);
        #1;
        checkOutput("idle_mom_ready", 64'(req_ready), 64'd0);
        tick();
        checkOutput("idle_mom_valid", 64'(dp_valid), 64'd0);
        clearAll();

        // All four hold SOM_EOM: one grant per cycle, 0,1,2,3,0,...
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, SOM_EOM, 64'hB0 + 64'(i));
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            checkOutput($sformatf("rr_grant%0d", k), 64'(grant_id), 64'(k % 4));
            checkOutput($sformatf("rr_data%0d", k), dp_data, 64'hB0 + 64'(k % 4));
            checkOutput($sformatf("rr_valid%0d", k), 64'(dp_valid), 64'd1);
        end
        clearAll();

        // Requester 2 mid-packet, requester 0 raises SOM and must wait
        doReset();
        applyStimulus(2, 1'b1, SOM, 64'hC0);
        tick();
        checkOutput("atom_d0", dp_data, 64'hC0);
        applyStimulus(2, 1'b1, MOM, 64'hC1);
        applyStimulus(0, 1'b1, SOM, 64'hD0);
        #1;
        checkOutput("atom_ready1", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("atom_d1", dp_data, 64'hC1);
        applyStimulus(2, 1'b1, EOM, 64'hC2);
        #1;
        checkOutput("atom_ready2", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("atom_d2", dp_data, 64'hC2);
        checkOutput("atom_eom", 64'(dp_cntl), 64'(EOM));
        applyStimulus(2, 1'b0, MOM, 64'h0);
        #1;
        checkOutput("atom_ready3", 64'(req_ready), 64'b0001);
        tick();
        checkOutput("atom_d3", dp_data, 64'hD0);
        checkOutput("atom_grant", 64'(grant_id), 64'd0);
        clearAll();

        // Backpressure on beat 2 for five cycles
        doReset();
        applyStimulus(1, 1'b1, SOM, 64'hE0);
        tick();
        applyStimulus(1, 1'b1, MOM, 64'hE1);
        tick();
        checkOutput("bp_beat2", dp_data, 64'hE1);
        applyStimulus(1, 1'b1, EOM, 64'hE2);
        dp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("bp_ready%0d", k), 64'(req_ready), 64'd0);
            tick();
            checkOutput($sformatf("bp_hold_data%0d", k), dp_data, 64'hE1);
            checkOutput($sformatf("bp_hold_cntl%0d", k), 64'(dp_cntl), 64'(MOM));
            checkOutput($sformatf("bp_hold_valid%0d", k), 64'(dp_valid), 64'd1);
        end
        dp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(req_ready), 64'b0010);
        tick();
        checkOutput("bp_beat3", dp_data, 64'hE2);
        checkOutput("bp_beat3_cntl", 64'(dp_cntl), 64'(EOM));
        clearAll();
        tick();
        checkOutput("bp_drain", 64'(dp_valid), 64'd0);

        // Reset in the middle of a packet
        applyStimulus(1, 1'b1, SOM, 64'hF0);
        tick();
        applyStimulus(1, 1'b1, MOM, 64'hF1);
        tick();
        reset_poweron = 1'b1;
        #1;
        checkOutput("mrst_ready_in_reset", 64'(req_ready), 64'd0);
        tick();
        checkOutput("mrst_valid", 64'(dp_valid), 64'd0);
        checkOutput("mrst_data", dp_data, 64'd0);
        checkOutput("mrst_grant", 64'(grant_id), 64'd0);
        tick();
        tick();
        reset_poweron = 1'b0;
        #1;
        checkOutput("mrst_stale_mom_ready", 64'(req_ready), 64'd0);
        applyStimulus(1, 1'b0, MOM, 64'h0);
        applyStimulus(2, 1'b1, SOM_EOM, 64'h77);
        #1;
        checkOutput("mrst_new_ready", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("mrst_new_data", dp_data, 64'h77);
        checkOutput("mrst_new_grant", 64'(grant_id), 64'd2);
        clearAll();

        // Requesters 0 and 3 both hold SOM_EOM
        doReset();
        applyStimulus(0, 1'b1, SOM_EOM, 64'h90);
        applyStimulus(3, 1'b1, SOM_EOM, 64'h93);
        for (int k = 0; k < 6; k++) begin
            tick();
`ifdef MGR_NOC_TX_ARB_REQ0_PRIORITY_EN
            checkOutput($sformatf("prio_grant%0d", k), 64'(grant_id), 64'd0);
`else
            checkOutput($sformatf("prio_grant%0d", k), 64'(grant_id), (k % 2 == 0) ? 64'd0 : 64'd3);
`endif
        end
        clearAll();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
